mul_share_arbiter: RTL
======================

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL provide parameter: N_REQ, 4, number of requesters (fixed at 4 for this release; ID width 2).
REQ-002 SHALL provide port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port: req_valid  input  N_REQ  per-requester operand-pair valid.
REQ-005 SHALL provide port: req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-006 SHALL provide port: req_a  input  16*N_REQ  signed multiplicand, requester i in bits [16i+15:16i].
REQ-007 SHALL provide port: req_b  input  16*N_REQ  signed multiplier, same packing.
REQ-008 SHALL provide port: rsp_valid  output  1  product available.
REQ-009 SHALL provide port: rsp_ready  input  1  downstream accepts product.
REQ-010 SHALL provide port: rsp_id  output  2  index of requester owning rsp_data.
REQ-011 SHALL provide port: rsp_data  output  32  signed two's-complement product.
REQ-012 SHALL provide port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, HOLD; exactly one transaction in flight.
REQ-014 IDLE: when any req_valid high, SHALL assert req_ready for exactly one requester, the first valid at or after rr_ptr in ascending wrap-around order (3 wraps to 0).
REQ-015 req_ready SHALL be combinational from req_valid and rr_ptr, asserted only in IDLE, never to a requester whose req_valid is low.
REQ-016 On handshake (req_valid[i] && req_ready[i]) SHALL latch req_a/req_b slice i and id i into operand registers, set rr_ptr to (i+1) mod 4, go to CALC.
REQ-017 CALC: SHALL register the full 32-bit signed product of latched operands into rsp_data and id into rsp_id, go to HOLD; CALC lasts exactly one cycle.
REQ-018 HOLD: rsp_valid SHALL be 1; rsp_data/rsp_id SHALL stay stable until rsp_ready sampled high, then go to IDLE with rsp_valid 0 next cycle.
REQ-019 Latency: handshake in cycle N SHALL yield rsp_valid high in cycle N+2; with rsp_ready held high, next acceptance earliest cycle N+3.
REQ-020 rsp_valid SHALL be 0 in IDLE and CALC; busy SHALL equal (state != IDLE).
REQ-021 Product SHALL be exact for all operand pairs, including 0x8000*0x8000 = 0x40000000 and 0x8000*0x7FFF = 0xC0008000.
REQ-022 req_valid changes outside the handshake cycle SHALL have no effect; operand changes after handshake SHALL not affect the product.
REQ-023 rr_ptr SHALL change only on a handshake; no grant when all req_valid low.

Reset
REQ-024 rst_n low at a clock edge SHALL force state IDLE, rr_ptr 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, operand registers 0.
REQ-025 rst_n asserted mid-transaction (CALC or HOLD) SHALL discard the transaction without emitting a response; req_ready SHALL be 0 while rst_n low.

Structure
REQ-026 Shared package SHALL hold N_REQ, ID width, operand width 16, product width 32, and the state encoding enum.
REQ-027 SHALL instantiate exactly one TopMultiplier (16x16 Booth/Wallace signed core) as sole sub-module, fed from the operand registers; arbiter, FSM and registers in this module.
REQ-028 Combinational path req_valid -> req_ready SHALL not pass through the multiplier.

Verification
REQ-029 Single request: req 2 valid, a=0xFFFD (-3), b=0x0007 -> rsp_valid at N+2, rsp_id=2, rsp_data=0xFFFFFFEB.
REQ-030 Round-robin: all four valid continuously, rsp_ready=1 from reset -> grant order 0,1,2,3,0; each rsp_id matches.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in HOLD -> rsp_valid, rsp_data, rsp_id stable, req_ready all 0 throughout; response consumed on first rsp_ready=1, IDLE next cycle.
REQ-032 Corner operands: 0x8000*0x8000 -> 0x40000000; 0x8000*0x7FFF -> 0xC0008000; 0x0000*0xFFFF -> 0x00000000.
REQ-033 Reset mid-HOLD: rst_n low one cycle while rsp_valid=1 -> next cycle rsp_valid 0, busy 0, rr_ptr 0; no response for that transaction.
REQ-034 Pointer skip: rr_ptr=1, only req 0 and 3 valid -> req 3 granted first, then req 0.

Source files
------------

// File: rtl/mul_share_arbiter_pkg.sv
// Shared constants, FSM encoding and adder-tree helper
// for the shared-multiplier arbiter.
package mul_share_arbiter_pkg;

  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
  } csa_t;

  // 3:2 carry-save compressor; carry is pre-shifted
  function automatic csa_t csa(
    input logic [PROD_W-1:0] x,
    input logic [PROD_W-1:0] y,
    input logic [PROD_W-1:0] z
  );
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_mult.sv
// 16x16 signed multiplier: radix-4 Booth partial
// products reduced by a carry-save tree.
module TopMultiplier
  import mul_share_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] a_ext;
  logic [OP_W:0]     be;
  logic [PROD_W-1:0] pp [8];
  logic [2:0]        trip;
  logic [PROD_W-1:0] v;

  assign a_ext = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
  assign be    = {b, 1'b0};

  always_comb begin
    trip = '0;
    v    = '0;
    for (int j = 0; j < 8; j++) begin
      trip = be[2*j+2 -: 3];
      unique case (trip)
        3'b001, 3'b010: v = a_ext;
        3'b011:         v = a_ext << 1;
        3'b100:         v = -(a_ext << 1);
        3'b101, 3'b110: v = -a_ext;
        default:        v = '0;
      endcase
      pp[j] = v << (2 * j);
    end
  end

  // Reduction: 8 -> 6 -> 4 -> 3 -> 2 rows
  csa_t l1a, l1b, l2a, l2b, l3, l4;

  assign l1a = csa(pp[0], pp[1], pp[2]);
  assign l1b = csa(pp[3], pp[4], pp[5]);
  assign l2a = csa(l1a.s, l1a.c, l1b.s);
  assign l2b = csa(l1b.c, pp[6], pp[7]);
  assign l3  = csa(l2a.s, l2a.c, l2b.s);
  assign l4  = csa(l3.s, l3.c, l2b.c);

  assign p = l4.s + l4.c;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one signed multiplier
// among four requesters, one transaction in flight.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int N_REQ = mul_share_arbiter_pkg::N_REQ
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [OP_W*N_REQ-1:0]  req_a,
  input  logic [OP_W*N_REQ-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PROD_W-1:0]      rsp_data,
  output logic                   busy
);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   op_id;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [PROD_W-1:0] prod;

  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   cand;
  logic              found;

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_id    = '0;
    cand      = '0;
    found     = 1'b0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = rr_ptr + ID_W'(k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
    if (rst_n && state == IDLE && found)
      req_ready[gnt_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  TopMultiplier u_mult (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            op_a   <= req_a[gnt_id*OP_W +: OP_W];
            op_b   <= req_b[gnt_id*OP_W +: OP_W];
            op_id  <= gnt_id;
            rr_ptr <= gnt_id + 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_data  <= prod;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
